regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 74 +++++++
 tb/tb_regfile_wb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester writeback arbiter with a per-register pending scoreboard.
// Define REGFILE_WB_ARB_FIXED_PRI_EN for fixed req0 priority instead of round-robin.
module regfile_wb_arbiter #(
  parameter int INDEX_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH  = 32,
  parameter int N_REGS          = 1 << INDEX_BIT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [INDEX_BIT_WIDTH-1:0] req0_index,
  input  logic [DATA_BIT_WIDTH-1:0]  req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [INDEX_BIT_WIDTH-1:0] req1_index,
  input  logic [DATA_BIT_WIDTH-1:0]  req1_data,
  output logic                       wrtEn,
  output logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
  output logic [DATA_BIT_WIDTH-1:0]  dataIn,
  input  logic                       issue_valid,
  input  logic [INDEX_BIT_WIDTH-1:0] issue_index,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
  output logic                       hazard1,
  output logic                       hazard2
);
  logic                       rr_ptr_q, rr_ptr_d;
  logic                       wrt_en_q, wrt_en_d;
  logic [INDEX_BIT_WIDTH-1:0] wrt_index_q, wrt_index_d;
  logic [DATA_BIT_WIDTH-1:0]  data_in_q, data_in_d;
  logic [N_REGS-1:0]          pending_q, pending_d;
  logic                       grant0, grant1;
  always_comb begin
`ifdef REGFILE_WB_ARB_FIXED_PRI_EN
    grant0   = reset_n && req0_valid;
    grant1   = reset_n && req1_valid && !req0_valid;
    rr_ptr_d = 1'b0;
`else
    grant0   = reset_n && req0_valid && (!req1_valid || !rr_ptr_q);
    grant1   = reset_n && req1_valid && (!req0_valid || rr_ptr_q);
    rr_ptr_d = grant0 ? 1'b1 : grant1 ? 1'b0 : rr_ptr_q;
`endif
    wrt_en_d    = grant0 || grant1;
    wrt_index_d = grant0 ? req0_index : grant1 ? req1_index : wrt_index_q;
    data_in_d   = grant0 ? req0_data : grant1 ? req1_data : data_in_q;
    // a same-cycle issue to the register being written keeps it pending
    for (int i = 0; i < N_REGS; i++)
      pending_d[i] = (issue_valid && issue_index == INDEX_BIT_WIDTH'(i)) ||
                     (pending_q[i] && !(wrt_en_q && wrt_index_q == INDEX_BIT_WIDTH'(i)));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= 1'b0;
      wrt_en_q    <= 1'b0;
      wrt_index_q <= '0;
      data_in_q   <= '0;
      pending_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wrt_en_q    <= wrt_en_d;
      wrt_index_q <= wrt_index_d;
      data_in_q   <= data_in_d;
      pending_q   <= pending_d;
    end
  end
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wrtEn      = wrt_en_q;
  assign wrtIndex   = wrt_index_q;
  assign dataIn     = data_in_q;
  assign hazard1    = reset_n && pending_q[rdIndex1] && !(wrt_en_q && wrt_index_q == rdIndex1);
  assign hazard2    = reset_n && pending_q[rdIndex2] && !(wrt_en_q && wrt_index_q == rdIndex2);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven arbitration vectors with a latency-1 write scoreboard,
// plus hand sequences for scoreboard hazards and mid-cycle reset.
module tb_regfile_wb_arbiter;
`ifdef REGFILE_WB_ARB_FIXED_PRI_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  typedef struct {
    logic r0v, r1v;
    logic [3:0] i0, i1;
    logic [31:0] d0, d1;
    logic e0, e1;
  } vec_t;
  typedef struct {
    logic en;
    logic [3:0] idx;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0, reset_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_index, req1_index, wrtIndex, issue_index, rdIndex1, rdIndex2;
  logic [31:0] req0_data, req1_data, dataIn;
  logic wrtEn, issue_valid, hazard1, hazard2;
  int errors = 0, checks = 0;
  wr_t sb[$];
  logic [3:0] last_idx = '0;
  logic [31:0] last_data = '0;
  vec_t tbl[11];
  vec_t v;
  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_index(req0_index), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_index(req1_index), .req1_data(req1_data),
    .wrtEn(wrtEn), .wrtIndex(wrtIndex), .dataIn(dataIn),
    .issue_valid(issue_valid), .issue_index(issue_index),
    .rdIndex1(rdIndex1), .rdIndex2(rdIndex2), .hazard1(hazard1), .hazard2(hazard2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic pop_check();
    wr_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("wrtEn", 32'(wrtEn), 32'(x.en));
      chk("wrtIndex", 32'(wrtIndex), 32'(x.idx));
      chk("dataIn", dataIn, x.data);
    end
  endtask
  task automatic tick(input vec_t t);
    @(posedge clk); #1;
    pop_check();
    req0_valid = t.r0v; req0_index = t.i0; req0_data = t.d0;
    req1_valid = t.r1v; req1_index = t.i1; req1_data = t.d1;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(t.e0));
    chk("req1_ready", 32'(req1_ready), 32'(t.e1));
    if (t.e0) begin last_idx = t.i0; last_data = t.d0; end
    else if (t.e1) begin last_idx = t.i1; last_data = t.d1; end
    sb.push_back('{t.e0 || t.e1, last_idx, last_data});
  endtask
  task automatic flush();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    pop_check();
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'd1, 4'd2, 32'hA1, 32'hA2, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'd1, 4'd2, 32'hB1, 32'hB2, FP, !FP};
    tbl[2]  = '{1'b1, 1'b1, 4'd1, 4'd2, 32'hC1, 32'hC2, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'd1, 4'd2, 32'hD1, 32'hD2, FP, !FP};
    tbl[4]  = '{1'b1, 1'b0, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'd0, 4'd4, 32'h0, 32'h44, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'd6, 4'd0, 32'h66, 32'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'd8, 4'd9, 32'h88, 32'h99, FP, !FP};
    tbl[9]  = '{1'b0, 1'b1, 4'd0, 4'd12, 32'h0, 32'hCC, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    reset_n = 1'b0; issue_valid = 1'b0; issue_index = '0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_index = 4'd5; req1_index = 4'd6;
    req0_data = 32'h1; req1_data = 32'h2; rdIndex1 = 4'd1; rdIndex2 = 4'd2;
    #2;
    chk("rst_wrtEn", 32'(wrtEn), 0);
    chk("rst_wrtIndex", 32'(wrtIndex), 0);
    chk("rst_dataIn", dataIn, 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_hazard1", 32'(hazard1), 0);
    #6 reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick(tbl[i]);
    flush();
    // issue 5, hold it pending, then write it back
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_index = 4'd5; rdIndex1 = 4'd5; rdIndex2 = 4'd5;
    #1 chk("h1_before_issue", 32'(hazard1), 0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    #1 chk("h1_pending5", 32'(hazard1), 1);
    chk("h2_pending5", 32'(hazard2), 1);
    req0_valid = 1'b1; req0_index = 4'd5; req0_data = 32'h55;
    #1 chk("wb5_ready", 32'(req0_ready), 1);
    chk("h1_accept_cycle", 32'(hazard1), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1 chk("wb5_wrtEn", 32'(wrtEn), 1);
    chk("wb5_wrtIndex", 32'(wrtIndex), 5);
    chk("wb5_dataIn", dataIn, 32'h55);
    chk("h1_bypass5", 32'(hazard1), 0);
    @(posedge clk); #2;
    chk("wb5_idle_wrtEn", 32'(wrtEn), 0);
    chk("h1_cleared5", 32'(hazard1), 0);
    // issue 7 coincides with the write to 7: set wins
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_index = 4'd7; req0_data = 32'h77; rdIndex1 = 4'd7;
    @(posedge clk); #1;
    req0_valid = 1'b0; issue_valid = 1'b1; issue_index = 4'd7;
    #1 chk("wb7_wrtEn", 32'(wrtEn), 1);
    chk("h1_wb7_cycle", 32'(hazard1), 0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    #1 chk("h1_set_wins7", 32'(hazard1), 1);
    // pending 2 and 9, write in flight, asynchronous reset mid-cycle
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_index = 4'd2;
    @(posedge clk); #1;
    issue_index = 4'd9;
    @(posedge clk); #1;
    issue_valid = 1'b0; rdIndex1 = 4'd2; rdIndex2 = 4'd9;
    req0_valid = 1'b1; req0_index = 4'd9; req0_data = 32'h99;
    #1 chk("pre_h1", 32'(hazard1), 1);
    chk("pre_h2", 32'(hazard2), 1);
    @(posedge clk); #1;
    req0_index = 4'd2; req0_data = 32'h22;
    #1 chk("inflight_wrtEn", 32'(wrtEn), 1);
    chk("inflight_h1", 32'(hazard1), 1);
    chk("inflight_h2", 32'(hazard2), 0);
    chk("inflight_ready", 32'(req0_ready), 1);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_wrtEn", 32'(wrtEn), 0);
    chk("mid_rst_h1", 32'(hazard1), 0);
    chk("mid_rst_h2", 32'(hazard2), 0);
    chk("mid_rst_ready", 32'(req0_ready), 0);
    chk("mid_rst_dataIn", dataIn, 0);
    @(posedge clk); #2;
    reset_n = 1'b1; req0_valid = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_wrtEn", 32'(wrtEn), 0);
    chk("post_rst_h1", 32'(hazard1), 0);
    chk("post_rst_h2", 32'(hazard2), 0);
    sb.delete(); last_idx = '0; last_data = '0;
    v = '{1'b1, 1'b1, 4'd10, 4'd11, 32'hAA, 32'hBB, 1'b1, 1'b0};
    tick(v);
    v = '{1'b1, 1'b1, 4'd10, 4'd11, 32'hAB, 32'hBC, FP, !FP};
    tick(v);
    flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
